mult18_rr_sched: RTL and testbench



---
 rtl/mult18_rr_sched.sv | 138 +++++++++++++
 tb/tb_mult18_rr_sched.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult18_rr_sched.sv
// mult18_rr_sched: round-robin front end that shares one external registered
// 18x18 signed multiplier among NREQ requesters. The multiplier's output
// register acts as a one-entry result buffer. The product-valid flag (pv) and
// the owner tag (ptag) follow the operands through that register.
//
// Optional feature, enabled by defining MULT18_RR_SCHED_BUSY_CNT_EN:
//   This adds a saturating grant counter (BUSY_CNT) and its clear input (CNT_CLR).
module mult18_rr_sched #(
    parameter int NREQ = 4,
    parameter int CNTW = 32
) (
    input  logic               C,
    input  logic               R_N,
    input  logic [NREQ-1:0]    REQ,
    input  logic [NREQ*18-1:0] A_IN,
    input  logic [NREQ*18-1:0] B_IN,
    output logic [NREQ-1:0]    GNT,
    output logic               RES_VLD,
    output logic [NREQ-1:0]    RES_SEL,
    output logic [35:0]        RES_P,
    input  logic               RES_RDY,
    output logic [17:0]        M_A,
    output logic [17:0]        M_B,
    output logic               M_CE,
    output logic               M_R,
    input  logic [35:0]        M_P
`ifdef MULT18_RR_SCHED_BUSY_CNT_EN
    ,
    input  logic               CNT_CLR,
    output logic [CNTW-1:0]    BUSY_CNT
`endif
);

    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Occupancy of the multiplier output register, decoded from pv and RES_RDY.
    typedef enum logic [1:0] {
        OCC_EMPTY,  // nothing held
        OCC_FULL,   // result held and leaving this cycle; refill allowed
        OCC_STALL   // result held and consumer not ready; freeze everything
    } occ_e;

    occ_e              occ;
    logic              advance;
    logic              pv_q, pv_d;
    logic [NREQ-1:0]   ptag_q, ptag_d;
    logic [PTRW-1:0]   ptr_q, ptr_d;
    logic              win_vld;
    logic [PTRW-1:0]   win_idx;
    logic [NREQ-1:0]   win_oh;

    // Decode the occupancy state from the held flag and consumer readiness.
    always_comb begin
        occ = OCC_EMPTY;
        if (pv_q) begin
            occ = RES_RDY ? OCC_FULL : OCC_STALL;
        end
    end

    assign advance = (occ != OCC_STALL);

    // Rotating-priority search. It starts one past the last winner and wraps.
    always_comb begin
        // NOTE: Every variable assigned in this block gets a default first,
        // so no path can leave a value held. That is what keeps a latch out.
        win_vld = 1'b0;
        win_idx = '0;
        win_oh  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            logic [PTRW-1:0] cand;
            cand = PTRW'((int'(ptr_q) + k) % NREQ);
            if (!win_vld && REQ[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
        win_oh[win_idx] = win_vld;
    end

    // A grant is issued only when the output register can take a new product.
    assign GNT = (advance && R_N) ? win_oh : '0;

    assign M_A  = win_vld ? A_IN[int'(win_idx)*18 +: 18] : '0;
    assign M_B  = win_vld ? B_IN[int'(win_idx)*18 +: 18] : '0;
    assign M_CE = advance & R_N;
    assign M_R  = ~R_N;

    // Next-state logic. The tag and valid flag move in lockstep with the multiplier CE.
    always_comb begin
        pv_d   = pv_q;
        ptag_d = ptag_q;
        ptr_d  = ptr_q;
        if (advance) begin
            pv_d   = |GNT;
            ptag_d = GNT;
            if (|GNT) begin
                ptr_d = win_idx;
            end
        end
    end

    // State register. Reset makes requester 0 the first in line.
    always_ff @(posedge C) begin
        // NOTE: Sequential state uses non-blocking assignments only. All
        // registers then update together from the values before the edge.
        if (!R_N) begin
            pv_q   <= 1'b0;
            ptag_q <= '0;
            ptr_q  <= PTRW'(NREQ - 1);
        end else begin
            pv_q   <= pv_d;
            ptag_q <= ptag_d;
            ptr_q  <= ptr_d;
        end
    end

    assign RES_VLD = pv_q & R_N;
    assign RES_SEL = ptag_q & {NREQ{RES_VLD}};
    assign RES_P   = M_P;

`ifdef MULT18_RR_SCHED_BUSY_CNT_EN
    logic [CNTW-1:0] cnt_q;

    // Saturating count of granted cycles. A clear takes priority over counting.
    always_ff @(posedge C) begin
        if (!R_N) begin
            cnt_q <= '0;
        end else if (CNT_CLR) begin
            cnt_q <= '0;
        end else if ((|GNT) && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign BUSY_CNT = cnt_q;
`endif

endmodule

// File: tb/tb_mult18_rr_sched.sv
// Directed testbench for mult18_rr_sched. It models the external registered
// multiplier. The stimulus pushes the hand-computed result expected for each
// grant into a scoreboard. A monitor pops and compares on every accepted result.
module tb_mult18_rr_sched;

    localparam int NREQ = 4;
    localparam int CNTW = 32;

    logic               clk;
    logic               r_n;
    logic [NREQ-1:0]    req;
    logic [NREQ*18-1:0] a_in;
    logic [NREQ*18-1:0] b_in;
    logic [NREQ-1:0]    gnt;
    logic               res_vld;
    logic [NREQ-1:0]    res_sel;
    logic [35:0]        res_p;
    logic               res_rdy;
    logic [17:0]        m_a;
    logic [17:0]        m_b;
    logic               m_ce;
    logic               m_r;
    logic [35:0]        m_p;
`ifdef MULT18_RR_SCHED_BUSY_CNT_EN
    logic               cnt_clr;
    logic [CNTW-1:0]    busy_cnt;
`endif

    logic signed [17:0] a_op [NREQ];
    logic signed [17:0] b_op [NREQ];

    int n_tests = 0;
    int n_fail  = 0;

    logic [39:0] sb [$];   // {expected RES_SEL, expected RES_P}

    mult18_rr_sched #(.NREQ(NREQ), .CNTW(CNTW)) dut (
        .C       (clk),
        .R_N     (r_n),
        .REQ     (req),
        .A_IN    (a_in),
        .B_IN    (b_in),
        .GNT     (gnt),
        .RES_VLD (res_vld),
        .RES_SEL (res_sel),
        .RES_P   (res_p),
        .RES_RDY (res_rdy),
        .M_A     (m_a),
        .M_B     (m_b),
        .M_CE    (m_ce),
        .M_R     (m_r),
        .M_P     (m_p)
`ifdef MULT18_RR_SCHED_BUSY_CNT_EN
        ,
        .CNT_CLR (cnt_clr),
        .BUSY_CNT(busy_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar i = 0; i < NREQ; i++) begin : g_pack
        assign a_in[18*i +: 18] = a_op[i];
        assign b_in[18*i +: 18] = b_op[i];
    end

    // Behavioural model of the external multiplier. Its product is registered,
    // it has a synchronous clear, and it has a clock enable.
    always @(posedge clk) begin
        if (m_r)
            m_p <= '0;
        else if (m_ce)
            m_p <= $signed({{18{m_a[17]}}, m_a}) * $signed({{18{m_b[17]}}, m_b});
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted result must match the oldest expectation.
    always @(negedge clk) begin
        if (res_vld && res_rdy) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: got sel %h p %h expected none", res_sel, res_p);
            end else begin
                logic [39:0] e;
                e = sb.pop_front();
                check("res_sel", 64'(res_sel), 64'(e[39:36]));
                check("res_p",   64'(res_p),   64'(e[35:0]));
            end
        end else if (!res_vld) begin
            check("idle_sel", 64'(res_sel), 64'(0));
        end
    end

    // Drive one cycle of inputs. Check the grant mid-cycle and queue the expected result.
    task automatic drive(input logic [3:0] r, input logic rdy, input logic [3:0] exp_gnt,
                         input logic [35:0] exp_p, input bit push = 1'b1);
        req     = r;
        res_rdy = rdy;
        @(negedge clk);
        check("gnt", 64'(gnt), 64'(exp_gnt));
        if (push && exp_gnt != 4'b0000)
            sb.push_back({exp_gnt, exp_p});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        r_n     = 1'b0;
        req     = '0;
        res_rdy = 1'b1;
`ifdef MULT18_RR_SCHED_BUSY_CNT_EN
        cnt_clr = 1'b0;
`endif
        // Requester products:
        //   0: 3*-5 = -15 -> FFFFFFFF1
        //   1: -7*11 = -77 -> FFFFFFFB3
        //   2: 100*-200 = -20000 -> FFFFFB1E0
        //   3: -131072*131071 = -(2^34-2^17) -> C00020000
        a_op[0] = 18'sd3;       b_op[0] = -18'sd5;
        a_op[1] = -18'sd7;      b_op[1] = 18'sd11;
        a_op[2] = 18'sd100;     b_op[2] = -18'sd200;
        a_op[3] = -18'sd131072; b_op[3] = 18'sd131071;

        // Reset state
        @(negedge clk);
        check("rst_gnt", 64'(gnt), 64'(0));
        check("rst_vld", 64'(res_vld), 64'(0));
        check("rst_m_r", 64'(m_r), 64'(1));
        check("rst_m_ce", 64'(m_ce), 64'(0));
        @(posedge clk);
        #1;
        r_n = 1'b1;

        // Round robin from reset with all requesting: 0,1,2,3,0, back to back
        drive(4'b1111, 1'b1, 4'b0001, 36'hFFFFFFFF1);
        drive(4'b1111, 1'b1, 4'b0010, 36'hFFFFFFFB3);
        drive(4'b1111, 1'b1, 4'b0100, 36'hFFFFFB1E0);
        drive(4'b1111, 1'b1, 4'b1000, 36'hC00020000);
        drive(4'b1111, 1'b1, 4'b0001, 36'hFFFFFFFF1);
        // Two requesters alternate
        drive(4'b1010, 1'b1, 4'b0010, 36'hFFFFFFFB3);
        drive(4'b1010, 1'b1, 4'b1000, 36'hC00020000);
        drive(4'b1010, 1'b1, 4'b0010, 36'hFFFFFFFB3);
        drive(4'b1010, 1'b1, 4'b1000, 36'hC00020000);
        // Single request, then the most negative operand squared: 2^34
        drive(4'b0001, 1'b1, 4'b0001, 36'hFFFFFFFF1);
        a_op[1] = -18'sd131072; b_op[1] = -18'sd131072;
        drive(4'b0010, 1'b1, 4'b0010, 36'h400000000);
        drive(4'b0000, 1'b1, 4'b0000, 36'h0);

        // Backpressure: hold a result for three cycles while requester 0 waits
        drive(4'b0100, 1'b1, 4'b0100, 36'hFFFFFB1E0);
        repeat (3) begin
            req     = 4'b0001;
            res_rdy = 1'b0;
            @(negedge clk);
            check("stall_gnt", 64'(gnt), 64'(0));
            check("stall_ce",  64'(m_ce), 64'(0));
            check("stall_vld", 64'(res_vld), 64'(1));
            check("stall_sel", 64'(res_sel), 64'(4'b0100));
            check("stall_p",   64'(res_p), 64'(36'hFFFFFB1E0));
            @(posedge clk);
            #1;
        end
        // The held result drains and requester 0 is granted in the same cycle
        drive(4'b0001, 1'b1, 4'b0001, 36'hFFFFFFFF1);
        drive(4'b0000, 1'b1, 4'b0000, 36'h0);

        // Reset while a product is in flight: the product is discarded
        drive(4'b1000, 1'b1, 4'b1000, 36'h0, 1'b0);
        r_n = 1'b0;
        req = 4'b0000;
        @(negedge clk);
        check("mid_rst_m_r", 64'(m_r), 64'(1));
        check("mid_rst_ce",  64'(m_ce), 64'(0));
        check("mid_rst_gnt", 64'(gnt), 64'(0));
        check("mid_rst_vld", 64'(res_vld), 64'(0));
        @(posedge clk);
        #1;
        r_n = 1'b1;
        @(negedge clk);
        check("post_rst_vld", 64'(res_vld), 64'(0));
        check("post_rst_m_p", 64'(m_p), 64'(0));
        @(posedge clk);
        #1;
        drive(4'b1111, 1'b1, 4'b0001, 36'hFFFFFFFF1);
        drive(4'b0000, 1'b1, 4'b0000, 36'h0);

`ifdef MULT18_RR_SCHED_BUSY_CNT_EN
        // Busy counter: clear, ten grants, read, clear again
        cnt_clr = 1'b1;
        drive(4'b0000, 1'b1, 4'b0000, 36'h0);
        cnt_clr = 1'b0;
        repeat (10) drive(4'b0001, 1'b1, 4'b0001, 36'hFFFFFFFF1);
        req     = 4'b0000;
        cnt_clr = 1'b1;
        @(negedge clk);
        check("busy_cnt_10", 64'(busy_cnt), 64'(10));
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        @(negedge clk);
        check("busy_cnt_clr", 64'(busy_cnt), 64'(0));
        @(posedge clk);
        #1;
`endif

        repeat (3) drive(4'b0000, 1'b1, 4'b0000, 36'h0);
        check("drain", 64'(sb.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
